// File: rtl/cv32e40p_regfile_snap.sv
// cv32e40p integer register file with NUM_READ combinational read ports,
// two write ports (B over A) and a snapshot engine. The engine captures the
// SNAP_MASK-selected registers into shadow storage in one cycle, then streams
// them out in ascending index order over a valid/ready handshake.
// Optional feature macro: RF_WR_BYPASS_EN (write-to-read same-cycle bypass).
module cv32e40p_regfile_snap #(
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 32,
   parameter int NUM_READ   = 3,
   parameter logic [(2**ADDR_WIDTH)-1:0] SNAP_MASK = 32'h0000_FC0E
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [NUM_READ*ADDR_WIDTH-1:0] raddr_i,
   output logic [NUM_READ*DATA_WIDTH-1:0] rdata_o,
   input  logic [ADDR_WIDTH-1:0]          waddr_a_i,
   input  logic [DATA_WIDTH-1:0]          wdata_a_i,
   input  logic                           we_a_i,
   input  logic [ADDR_WIDTH-1:0]          waddr_b_i,
   input  logic [DATA_WIDTH-1:0]          wdata_b_i,
   input  logic                           we_b_i,
   input  logic                           snap_req_i,
   output logic                           snap_busy_o,
   output logic                           snap_valid_o,
   input  logic                           snap_ready_i,
   output logic [ADDR_WIDTH-1:0]          snap_idx_o,
   output logic [DATA_WIDTH-1:0]          snap_data_o,
   output logic                           snap_last_o
);

   localparam int NUM_WORDS = 2**ADDR_WIDTH;
   // R0 is never part of a snapshot
   localparam logic [NUM_WORDS-1:0] EFF_MASK = {SNAP_MASK[NUM_WORDS-1:1], 1'b0};

   typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DONE} state_t;

   state_t                  state, state_nxt;
   logic [DATA_WIDTH-1:0]   mem    [NUM_WORDS];
   logic [DATA_WIDTH-1:0]   shadow [NUM_WORDS];
   logic [NUM_WORDS-1:0]    pending;
   logic [NUM_WORDS-1:0]    pending_rest;
   logic [ADDR_WIDTH-1:0]   pick_idx;
   logic                    pick_last;
   logic                    start;
   logic                    accept;

   assign start  = (state == S_IDLE) && snap_req_i;
   assign accept = (state == S_STREAM) && snap_ready_i;

   // Live register storage; B wins on an address collision, R0 stays zero
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_WORDS; i++) mem[i] <= '0;
      end else begin
         for (int i = 1; i < NUM_WORDS; i++) begin
            if (we_b_i && (waddr_b_i == ADDR_WIDTH'(i)))
               mem[i] <= wdata_b_i;
            else if (we_a_i && (waddr_a_i == ADDR_WIDTH'(i)))
               mem[i] <= wdata_a_i;
         end
      end
   end

   for (genvar k = 0; k < NUM_READ; k++) begin : g_rd
      logic [ADDR_WIDTH-1:0] ra;
      logic [DATA_WIDTH-1:0] rd;
      assign ra = raddr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
      // Combinational read port, optionally forwarding same-cycle write data
      always_comb begin
         rd = mem[ra];
`ifdef RF_WR_BYPASS_EN
         if (ra != '0) begin
            if (we_b_i && (waddr_b_i == ra))
               rd = wdata_b_i;
            else if (we_a_i && (waddr_a_i == ra))
               rd = wdata_a_i;
         end
`else
`endif
      end
      assign rdata_o[k*DATA_WIDTH +: DATA_WIDTH] = rd;
   end

   // Shadow capture of pre-edge contents; never sees same-cycle writes
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_WORDS; i++) shadow[i] <= '0;
      end else if (start) begin
         for (int i = 0; i < NUM_WORDS; i++)
            if (EFF_MASK[i]) shadow[i] <= mem[i];
      end
   end

   // Remaining-beat mask: loaded on capture, lowest bit cleared per accepted beat
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         pending <= '0;
      else if (start)
         pending <= EFF_MASK;
      else if (accept)
         pending <= pending_rest;
   end

   // Lowest pending index and whether anything remains above it
   always_comb begin
      pick_idx = '0;
      for (int i = NUM_WORDS-1; i >= 0; i--)
         if (pending[i]) pick_idx = ADDR_WIDTH'(i);
      pending_rest           = pending;
      pending_rest[pick_idx] = 1'b0;
      pick_last              = (pending_rest == '0);
   end

   // Snapshot state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   // Snapshot next-state and stream outputs
   always_comb begin
      state_nxt    = state;
      snap_busy_o  = 1'b0;
      snap_valid_o = 1'b0;
      snap_idx_o   = '0;
      snap_data_o  = '0;
      snap_last_o  = 1'b0;
      case (state)
         S_IDLE: begin
            if (snap_req_i && (EFF_MASK != '0)) state_nxt = S_STREAM;
         end
         S_STREAM: begin
            snap_busy_o  = 1'b1;
            snap_valid_o = 1'b1;
            snap_idx_o   = pick_idx;
            snap_data_o  = shadow[pick_idx];
            snap_last_o  = pick_last;
            if (snap_ready_i && pick_last) state_nxt = S_DONE;
         end
         S_DONE: begin
            snap_busy_o = 1'b1;
            state_nxt   = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

endmodule

// File: doc/cv32e40p_regfile_snap.md
# cv32e40p_regfile_snap

Parametrised flip-flop integer register file for the cv32e40p core, generalised to a configurable number of read ports and register count, with an on-demand snapshot engine. A single request atomically captures a parameter-selected subset of registers into shadow storage, then streams it out one word per valid/ready beat. The snapshot path feeds the debug/IR-drop observation logic, so the core keeps executing and writing the live file while the stream drains.

## Interface
Parameters:
- ADDR_WIDTH, 5, register address width; NUM_WORDS = 2**ADDR_WIDTH.
- DATA_WIDTH, 32, register width.
- NUM_READ, 3, number of combinational read ports (1..4).
- SNAP_MASK, 32'h0000_FC0E, NUM_WORDS-bit mask of registers included in a snapshot; bit 0 is ignored.

Ports:
- clk  in  1  clock, all state rising-edge.
- rst  in  1  asynchronous active-high reset.
- raddr_i  in  NUM_READ*ADDR_WIDTH  read addresses; port k uses slice k.
- rdata_o  out  NUM_READ*DATA_WIDTH  read data; port k uses slice k.
- waddr_a_i / wdata_a_i / we_a_i  in  ADDR_WIDTH / DATA_WIDTH / 1  write port A.
- waddr_b_i / wdata_b_i / we_b_i  in  ADDR_WIDTH / DATA_WIDTH / 1  write port B, priority over A.
- snap_req_i  in  1  start-snapshot pulse; level is also accepted.
- snap_busy_o  out  1  snapshot captured and not fully drained.
- snap_valid_o  out  1  snapshot beat valid.
- snap_ready_i  in  1  consumer accepts beat.
- snap_idx_o  out  ADDR_WIDTH  register index of current beat.
- snap_data_o  out  DATA_WIDTH  captured value of that register.
- snap_last_o  out  1  current beat is the final one.

## Operation
- R0 reads 0 on every port; writes to R0 are discarded.
- Write: at the rising edge, mem[waddr_b_i] takes wdata_b_i if we_b_i is high. Otherwise mem[waddr_a_i] takes wdata_a_i if we_a_i is high. If both ports write the same address, B wins. If they write different addresses, both are committed.
- Read: rdata port k = mem[raddr k]. Reads are combinational, with no enable.
- Snapshot FSM has three states: IDLE, STREAM, DONE.
  - IDLE: when snap_req_i is sampled high, the full shadow of all mask-selected registers is loaded at that edge. The loaded values are the pre-edge register contents, so a write in the same cycle is not captured. The FSM goes to STREAM, or to IDLE if SNAP_MASK[NUM_WORDS-1:1] == 0, in which case no beats occur and busy stays low.
  - STREAM: snap_valid_o=1. snap_idx_o is the lowest pending mask index and snap_data_o is its shadow value. snap_last_o=1 when no higher mask bit remains. On valid&&ready the FSM advances to the next set bit in ascending order. When valid&&ready occurs with last=1, the FSM goes to DONE.
  - DONE: a single cycle with busy=1 and valid=0, then the FSM returns to IDLE. This guarantees one idle-busy cycle between streams.
- snap_req_i is ignored whenever the state is not IDLE, with no queueing.
- Live writes during STREAM/DONE update mem only; the shadow is unchanged.
- snap_valid_o stays high with stable idx/data/last until accepted. There is no timeout.

## Timing
- Reset (rst high, async): all mem and shadow entries = 0, FSM = IDLE. Outputs: snap_busy_o=0, snap_valid_o=0, snap_idx_o=0, snap_data_o=0, snap_last_o=0. rdata_o reflects zeroed mem.
- Reset during STREAM aborts the stream immediately; no further beats occur after release.
- Read latency 0 cycles. Write-to-read latency 1 cycle, or 0 with the bypass macro.
- Request latency: with snap_req_i sampled at edge t, busy and valid rise after edge t. The first beat is presentable in cycle t+1.
- Throughput is one beat per cycle with ready held high. A snapshot of P registers occupies P+1 busy cycles.
- Shadow index search: combinational priority pick over the remaining mask bits.

## Configuration
- RF_WR_BYPASS_EN defined: a read port whose address equals an active write address (non-zero) returns that write's data in the same cycle. B has priority over A, matching commit priority.
- RF_WR_BYPASS_EN undefined: reads return pre-edge mem contents. The snapshot capture never bypasses under either setting.

## Test plan
- Reset, then write R5=32'hDEAD_BEEF via A: the next cycle, all read ports at addr 5 return DEAD_BEEF, and addr 0 returns 0 after a write of 32'hFFFF_FFFF to R0.
- Same-cycle A and B writes to R7 (A=1, B=2): R7 reads 2. A and B writes to R8 and R9: both are committed.
- Default mask, R1..R15 = index value, ready high, request pulse: 9 beats, idx 1,2,3,10..15 with data equal to idx, last only on idx 15. Busy lasts 10 cycles.
- Snapshot with ready toggling 1-0-0-1, and R2 rewritten to 32'h1234 mid-stream: beats stall with stable outputs, and idx 2 still returns the captured value 2.
- rst asserted during the 4th beat: all outputs 0 the same cycle. After release, no beat appears until a new request, and a new request streams the reset (zero) values.
- With RF_WR_BYPASS_EN: write R3=32'hA5A5 while reading R3, and rdata shows A5A5 the same cycle. Without the macro it shows the old value.
